// File: rtl/seq_mult16_pkg.sv
// Shared constants and types for the sequential 16x16 shift-add multiplier.
package seq_mult16_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    // ALU control uses this code to select the multiplier result
    localparam logic [2:0] ALUOP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_mult16_ctrl.sv
// Sequencer for seq_mult16: FSM, iteration counter, busy/done and datapath strobes.
module seq_mult16_ctrl
    import seq_mult16_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    output logic load_c,
    output logic shift_c,
    output logic latch_c
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               w_last;

    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));
    assign load_c  = (r_state == ST_IDLE) && start;
    assign shift_c = (r_state == ST_CALC);
    assign latch_c = (r_state == ST_CALC) && w_last;
    assign busy    = r_busy;
    assign done    = r_done;

    // busy/done are registered alongside the state so they never glitch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_CALC;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/seq_mult16.sv
// Unsigned 16x16 shift-add multiplier, one add/shift step per clock, 32-bit product.
module seq_mult16
    import seq_mult16_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH:0]   r_acc;
    logic [2*WIDTH-1:0] r_product;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_hi;
    logic [2*WIDTH:0]   w_acc_shift;
    logic               w_load;
    logic               w_shift;
    logic               w_latch;

    seq_mult16_ctrl u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .load_c  (w_load),
        .shift_c (w_shift),
        .latch_c (w_latch)
    );

    // Conditional add into the high half; the carry lands in acc's top bit before shifting
    assign w_sum       = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    assign w_hi        = r_acc[0] ? w_sum : r_acc[2*WIDTH:WIDTH];
    assign w_acc_shift = {1'b0, w_hi, r_acc[WIDTH-1:1]};
    assign product     = r_product;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else begin
            if (w_load) begin
                r_mcand <= a;
                r_acc   <= {1'b0, WIDTH'(0), b};
            end else if (w_shift) begin
                r_acc <= w_acc_shift;
            end
            if (w_latch) begin
                r_product <= w_acc_shift[2*WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_seq_mult16.sv
// Directed-vector bench for seq_mult16: latency, handshake, reset abort and product hold.
module tb_seq_mult16;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int n_checks;
    int n_errors;

    seq_mult16 dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one multiply and follow it to completion; a/b are scrambled while iterating
    task automatic run_mult(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                            input logic [31:0] exp, input logic [31:0] prev, input bit keep_start);
        int cycles;
        int busy_cnt;
        int hold_bad;
        @(negedge clk);
        a = ta;
        b = tb_;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_start) start = 1'b0;
        cycles   = 0;
        busy_cnt = busy ? 1 : 0;
        hold_bad = 0;
        for (int k = 0; k < 40; k++) begin
            a = a + 16'h1111;
            b = b ^ 16'h5A5A;
            @(posedge clk);
            #1;
            cycles++;
            if (done) break;
            if (busy) busy_cnt++;
            if (product !== prev) hold_bad++;
        end
        check({tag, "_latency"}, 32'(cycles), 32'd16);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
        check({tag, "_hold"}, 32'(hold_bad), 32'd0);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_product"}, product, exp);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_idle_after_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", product, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_mult("m3x5", 16'd3, 16'd5, 32'h0000000F, 32'd0, 1'b0);
        run_mult("mffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 32'h0000000F, 1'b0);
        run_mult("m8000x2", 16'h8000, 16'h0002, 32'h00010000, 32'hFFFE0001, 1'b0);
        run_mult("mzero", 16'h0000, 16'h1234, 32'h00000000, 32'h00010000, 1'b0);

        // Held start: operands changing mid-CALC are ignored and the DONE-cycle start is dropped
        run_mult("hold10x10", 16'd10, 16'd10, 32'd100, 32'd0, 1'b1);
        run_mult("hold2x3", 16'd2, 16'd3, 32'd6, 32'd100, 1'b0);

        // Reset during iteration 8 aborts at once and clears the product
        @(negedge clk);
        a = 16'd3;
        b = 16'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", product, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_mult("m7x9", 16'd7, 16'd9, 32'd63, 32'd0, 1'b0);

        // Back-to-back: second start lands in the first available IDLE cycle
        run_mult("m100x200", 16'd100, 16'd200, 32'd20000, 32'd63, 1'b0);
        run_mult("m1234x5678", 16'h1234, 16'h5678, 32'h06260060, 32'd20000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
